// File: rtl/tree_sched_if.sv
// tree_sched_if: requester-side request/response bundle for the shared reduction tree scheduler
interface tree_sched_if #(parameter int NUM_REQ = 4);
  logic issue_en;
  logic [NUM_REQ-1:0] req_valid;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] resp_valid;
  logic resp_data;
  modport master(output issue_en, req_valid, req_data, input req_ready, resp_valid, resp_data);
  modport slave(input issue_en, req_valid, req_data, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/tree_sched.sv
// tree_sched: round-robin scheduler sharing one fixed-latency reduction tree among requesters
module tree_sched #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3,
  parameter int MAX_OUT = 2,
  localparam int IW = $clog2(LATENCY + 1),
  localparam int DW = $clog2(NUM_REQ),
  localparam int OW = $clog2(MAX_OUT + 1)
) (
  input  logic clk,
  input  logic rst,
  tree_sched_if.slave bus,
  output logic [15:0] tree_a,
  input  logic tree_b,
  output logic [IW-1:0] inflight,
  output logic busy
);
  logic [DW-1:0] ptr, g, rid;
  logic gnt, rsp;
  logic [LATENCY-1:0] tag_v;
  logic [DW-1:0] tag_id [LATENCY];
  logic [OW-1:0] out_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  assign rid = tag_id[LATENCY-1];
  assign rsp = tag_v[LATENCY-1] && !rst;
  // a response retiring this cycle frees its requester's slot for an immediate regrant
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign elig[i] = bus.req_valid[i] && bus.issue_en && !rst &&
                     (int'(out_cnt[i]) - int'(rsp && rid == DW'(i)) < MAX_OUT);
    assign bus.req_ready[i] = gnt && g == DW'(i);
    assign bus.resp_valid[i] = rsp && rid == DW'(i);
  end
  always_comb begin
    gnt = 1'b0;
    g = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (elig[(int'(ptr) + k) % NUM_REQ]) begin
        gnt = 1'b1;
        g = DW'((int'(ptr) + k) % NUM_REQ);
      end
  end
  assign tree_a = gnt ? bus.req_data[16*g +: 16] : 16'h0;
  assign bus.resp_data = tree_b;
  assign busy = !rst && inflight != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      tag_v <= '0;
      inflight <= '0;
      for (int i = 0; i < NUM_REQ; i++) out_cnt[i] <= '0;
    end else begin
      if (gnt) ptr <= (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
      tag_v <= LATENCY'({tag_v, gnt});
      inflight <= inflight + IW'(gnt) - IW'(rsp);
      for (int i = 0; i < NUM_REQ; i++)
        out_cnt[i] <= out_cnt[i] + OW'(gnt && g == DW'(i)) - OW'(rsp && rid == DW'(i));
    end
  end
  always_ff @(posedge clk) begin
    tag_id[0] <= g;
    for (int k = 1; k < LATENCY; k++) tag_id[k] <= tag_id[k-1];
  end
endmodule

// File: tb/tb_tree_sched.sv
// tb_tree_sched: directed stimulus against a queue-based scheduler model plus literal expectations
module tb_tree_sched;
  logic clk = 0, rst = 1, run = 0;
  logic [15:0] tree_a;
  logic tree_b;
  logic [1:0] inflight;
  logic busy;
  logic [15:0] d [4];
  logic [2:0] tsh = '0;
  int errors = 0, checks = 0, n = 0, ptr = 0;
  int outst [4] = '{default: 0};
  typedef struct { int due; int id; logic d; } ent_t;
  ent_t q[$];
  tree_sched_if #(.NUM_REQ(4)) bus();
  tree_sched dut (.clk(clk), .rst(rst), .bus(bus), .tree_a(tree_a), .tree_b(tree_b),
                  .inflight(inflight), .busy(busy));
  always #5 clk = ~clk;
  assign bus.req_data = {d[3], d[2], d[1], d[0]};
  // stand-in tree: 3-stage pipelined parity of the low byte
  always @(posedge clk) tsh <= {tsh[1:0], ^tree_a[7:0]};
  assign tree_b = tsh[2];
  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, n, got, exp);
    end
  endfunction
  always @(negedge clk) begin : model
    int g;
    bit due;
    logic [3:0] er, erv;
    logic [15:0] eta;
    if (run) begin
      due = q.size() > 0 && q[0].due == n;
      erv = (due && !rst) ? 4'b1 << q[0].id : 4'b0;
      g = -1;
      if (!rst && bus.issue_en)
        for (int k = 0; k < 4; k++)
          if (g < 0 && bus.req_valid[(ptr + k) % 4] &&
              outst[(ptr + k) % 4] - ((due && q[0].id == (ptr + k) % 4) ? 1 : 0) < 2)
            g = (ptr + k) % 4;
      er = g >= 0 ? 4'b1 << g : 4'b0;
      eta = g >= 0 ? d[g] : 16'h0;
      chk("m_req_ready", bus.req_ready, er);
      chk("m_tree_a", tree_a, eta);
      chk("m_resp_valid", bus.resp_valid, erv);
      if (erv != 0) chk("m_resp_data", bus.resp_data, q[0].d);
      chk("m_inflight", inflight, q.size());
      chk("m_busy", busy, !rst && q.size() != 0);
      chk("ready_onehot0", $onehot0(bus.req_ready), 1);
      chk("resp_onehot0", $onehot0(bus.resp_valid), 1);
      for (int i = 0; i < 4; i++) chk("outstanding_cap", dut.out_cnt[i] <= 2, 1);
      if (rst) begin
        q.delete();
        ptr = 0;
        outst = '{default: 0};
      end else begin
        if (due) begin
          outst[q[0].id]--;
          void'(q.pop_front());
        end
        if (g >= 0) begin
          q.push_back('{n + 3, g, ^d[g][7:0]});
          outst[g]++;
          ptr = (g + 1) % 4;
        end
      end
      n++;
    end
  end
  task automatic drive(input logic r, input logic e, input logic [3:0] v);
    @(posedge clk);
    #1;
    rst = r;
    bus.issue_en = e;
    bus.req_valid = v;
    @(negedge clk);
  endtask
  task automatic drain();
    for (int k = 0; k < 4; k++) drive(0, 1, 4'b0);
  endtask
  initial begin
    logic [3:0] rr_d;
    rr_d = 4'b0010;
    bus.issue_en = 1;
    bus.req_valid = '0;
    d = '{16'h0101, 16'h0, 16'h0, 16'h0};
    @(posedge clk);
    run = 1;
    drive(1, 1, 4'hF);
    chk("rst_ready", bus.req_ready, 4'b0);
    chk("rst_busy", busy, 0);
    chk("rst_tree_a", tree_a, 16'h0);
    drive(0, 1, 4'b0001);
    chk("single_ready", bus.req_ready, 4'b0001);
    chk("single_tree_a", tree_a, 16'h0101);
    drive(0, 1, 4'b0);
    chk("single_busy_t1", busy, 1);
    drive(0, 1, 4'b0);
    chk("single_busy_t2", busy, 1);
    drive(0, 1, 4'b0);
    chk("single_resp_valid", bus.resp_valid, 4'b0001);
    chk("single_resp_data", bus.resp_data, 1);
    chk("single_busy_t3", busy, 1);
    drive(0, 1, 4'b0);
    chk("single_idle", inflight, 0);
    d = '{16'hFFFF, 16'h0101, 16'h0303, 16'h0000};
    drive(1, 1, 4'b0);
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 4'hF);
      chk("rr_grant", bus.req_ready, 4'b1 << (k % 4));
      if (k >= 3) begin
        chk("rr_resp", bus.resp_valid, 4'b1 << ((k - 3) % 4));
        chk("rr_data", bus.resp_data, rr_d[(k - 3) % 4]);
      end
    end
    drain();
    drive(1, 1, 4'b0);
    for (int k = 0; k < 9; k++) begin
      drive(0, 1, 4'b0100);
      chk("cap_grant", bus.req_ready, (k % 3 == 2) ? 4'b0 : 4'b0100);
    end
    drain();
    drive(0, 1, 4'b0010);
    chk("skip_g1a", bus.req_ready, 4'b0010);
    drive(0, 1, 4'b0010);
    chk("skip_g1b", bus.req_ready, 4'b0010);
    drive(0, 1, 4'b1010);
    chk("skip_capped", bus.req_ready, 4'b1000);
    drive(0, 1, 4'b1011);
    chk("skip_wrap_ptr", bus.req_ready, 4'b0001);
    drain();
    drive(0, 1, 4'hF);
    chk("en_g1", bus.req_ready, 4'b0010);
    drive(0, 1, 4'hF);
    chk("en_g2", bus.req_ready, 4'b0100);
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 4'hF);
      chk("en_low_ready", bus.req_ready, 4'b0);
      if (j == 1) chk("en_resp1", bus.resp_valid, 4'b0010);
      if (j == 2) chk("en_resp2", bus.resp_valid, 4'b0100);
      if (j == 3) chk("en_inflight", inflight, 0);
    end
    drive(0, 1, 4'hF);
    chk("mid_g3", bus.req_ready, 4'b1000);
    drive(0, 1, 4'hF);
    chk("mid_g0", bus.req_ready, 4'b0001);
    drive(0, 1, 4'hF);
    chk("mid_g1", bus.req_ready, 4'b0010);
    drive(1, 1, 4'hF);
    chk("mid_rst_ready", bus.req_ready, 4'b0);
    chk("mid_rst_resp", bus.resp_valid, 4'b0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 4'b0);
      chk("mid_no_resp", bus.resp_valid, 4'b0);
      chk("mid_inflight", inflight, 0);
    end
    drive(0, 1, 4'hF);
    chk("mid_ptr0", bus.req_ready, 4'b0001);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
